// File: rtl/lsu_port_pkg.sv
// Shared constants for the load/store port: access-size codes, FSM state
// encoding, the registered-operation record and the alignment rule.
// No ports; imported by lsu_port, lsu_lane and the bench.

`ifndef LSU_PORT_CONSTS
`define LSU_PORT_CONSTS
`define memWord 2'd0
`define memHalf 2'd1
`define memByte 2'd2
`endif

package lsu_port_pkg;

  localparam logic [1:0] MEM_WORD = `memWord;
  localparam logic [1:0] MEM_HALF = `memHalf;
  localparam logic [1:0] MEM_BYTE = `memByte;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Everything captured from the pipeline at accept; nothing on req_* is
  // looked at again until the next accept.
  typedef struct packed {
    logic        we;
    logic [1:0]  part;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  // Half needs an even address, word needs a multiple of four; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] part, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (part)
      MEM_WORD: mis = (addr_lo != 2'b00);
      MEM_HALF: mis = addr_lo[0];
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_port_if.sv
// Bundle of the three handshakes around the load/store port:
// pipeline request (req_*), memory request/return (m_*), pipeline response (resp_*).
// Modport slave is the LSU's view; master is the surrounding pipeline + memory.

interface lsu_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_part;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        resp_ready;

  modport slave (
    input  req_valid, req_we, req_part, req_sext, req_addr, req_wdata,
    output req_ready,
    output m_valid, m_we, m_addr, m_be, m_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output resp_valid, resp_err, resp_data,
    input  resp_ready
  );

  modport master (
    output req_valid, req_we, req_part, req_sext, req_addr, req_wdata,
    input  req_ready,
    input  m_valid, m_we, m_addr, m_be, m_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  resp_valid, resp_err, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/lsu_port_lane.sv
// Byte-lane steering for the load/store port, purely combinational.
// Ports: part/sext/we/addr_lo describe the access; wdata -> be + wdata_lane
// for stores; rdata -> rdata_ext (selected lane, sign/zero extended) for loads.

module lsu_lane
  import lsu_port_pkg::*;
(
  input  logic [1:0]  part,
  input  logic        sext,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (part)
      MEM_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      MEM_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sext & half_lane[15]}}, half_lane};
      end
      default: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sext & byte_lane[7]}}, byte_lane};
      end
    endcase
    // Loads read the whole word; enables only qualify writes.
    if (!we) be = 4'b0000;
  end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding load/store port: accepts one op, checks alignment,
// issues one word-aligned memory request, returns an extended result.
// Ports: clk, reset (async active-low), bus (lsu_port_if.slave).

module lsu_port
  import lsu_port_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  lsu_port_if.slave    bus
);

  state_t      state, state_nxt;
  op_t         op_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic        accept;
  logic        misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign accept     = bus.req_valid && (state == ST_IDLE);
  assign misaligned = is_misaligned(bus.req_part, bus.req_addr[1:0]);

  lsu_lane u_lane (
    .part       (op_q.part),
    .sext       (op_q.sext),
    .we         (op_q.we),
    .addr_lo    (op_q.addr[1:0]),
    .wdata      (op_q.wdata),
    .rdata      (bus.m_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)        state_nxt = misaligned ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (bus.m_ready)   state_nxt = op_q.we ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (bus.m_rvalid)  state_nxt = ST_RESP;
      ST_RESP:  if (bus.resp_ready) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Operation and response registers. The response is zeroed at accept, so
  // stores and faults answer 0 without a separate path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (accept) begin
      op_q        <= '{we: bus.req_we, part: bus.req_part, sext: bus.req_sext,
                       addr: bus.req_addr, wdata: bus.req_wdata};
      resp_data_q <= '0;
      resp_err_q  <= misaligned;
    end else if (state == ST_WAIT && bus.m_rvalid) begin
      resp_data_q <= lane_rdata;
    end
  end

  // Outputs: everything is gated by state so idle/reset shows zeros.
  always_comb begin
    bus.req_ready  = (state == ST_IDLE);
    bus.m_valid    = 1'b0;
    bus.m_we       = 1'b0;
    bus.m_addr     = '0;
    bus.m_be       = '0;
    bus.m_wdata    = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_data  = '0;
    case (state)
      ST_ISSUE: begin
        bus.m_valid = 1'b1;
        bus.m_we    = op_q.we;
        bus.m_addr  = {op_q.addr[31:2], 2'b00};
        bus.m_be    = lane_be;
        bus.m_wdata = lane_wdata;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = resp_err_q;
        bus.resp_data  = resp_data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: directed cases followed by randomized operations,
// each checked against an arithmetic model of the access rules.
// Ports: none (top-level bench).

module tb_lsu_port;
  import lsu_port_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lsu_port_if bus ();

  lsu_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model -------------------------------------------------
  function automatic bit model_mis(input logic [1:0] part, input logic [31:0] addr);
    if (part == MEM_WORD) return (addr % 4) != 0;
    if (part == MEM_HALF) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [1:0] part, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (!we) return 4'd0;
    if (part == MEM_WORD) return 4'd15;
    if (part == MEM_HALF) return 4'(3 << off);
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] part, input logic [31:0] wd);
    if (part == MEM_WORD) return wd;
    if (part == MEM_HALF) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] part, input logic sext,
                                             input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    if (part == MEM_WORD) return rd;
    if (part == MEM_HALF) begin
      v = v & 32'hFFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    v = v & 32'hFF;
    if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  // ---- one complete operation ----------------------------------------
  // mdly: cycles m_ready stays low in ISSUE; rdly: cycles before m_rvalid;
  // rspdly: cycles resp_ready stays low in RESP (stray m_rvalid driven then).
  task automatic run_op(input logic we, input logic [1:0] part, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int mdly, input int rdly,
                        input int rspdly);
    bit          mis;
    logic [31:0] exp_data;
    mis      = model_mis(part, addr);
    exp_data = (mis || we) ? 32'd0 : model_load(part, sext, addr, rdata);

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_part  = part;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    chk("accept_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    // Scramble the request lines: the unit must work from its own copy.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_part  = 2'($urandom);
    bus.req_sext  = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    if (!mis) begin
      for (int i = 0; i <= mdly; i++) begin
        chk("issue_m_valid", 32'(bus.m_valid), 32'd1);
        chk("issue_m_we", 32'(bus.m_we), 32'(we));
        chk("issue_m_addr", bus.m_addr, addr - (addr % 4));
        chk("issue_m_be", 32'(bus.m_be), 32'(model_be(we, part, addr)));
        chk("issue_m_wdata", bus.m_wdata, model_wdata(part, wdata));
        chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
        chk("issue_resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.m_ready = (i == mdly);
        tick();
      end
      bus.m_ready = 1'b0;
      if (!we) begin
        for (int i = 0; i < rdly; i++) begin
          chk("wait_m_valid", 32'(bus.m_valid), 32'd0);
          chk("wait_resp_valid", 32'(bus.resp_valid), 32'd0);
          tick();
        end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = rdata;
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = $urandom;
      end
    end

    for (int i = 0; i <= rspdly; i++) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("resp_err", 32'(bus.resp_err), 32'(mis));
      chk("resp_data", bus.resp_data, exp_data);
      chk("resp_m_valid", 32'(bus.m_valid), 32'd0);
      chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
      bus.m_rvalid   = (i < rspdly);
      bus.m_rdata    = $urandom;
      bus.resp_ready = (i == rspdly);
      tick();
    end
    bus.m_rvalid   = 1'b0;
    bus.resp_ready = 1'b0;
    chk("done_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("done_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_part   = MEM_WORD;
    bus.req_sext   = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.m_ready    = 1'b0;
    bus.m_rvalid   = 1'b0;
    bus.m_rdata    = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_be", 32'(bus.m_be), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Byte store to lane 3, memory ready immediately
    run_op(1'b1, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    // Half loads from upper lane, signed then unsigned
    run_op(1'b0, MEM_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 0);
    run_op(1'b0, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 0);
    // Misaligned word load
    run_op(1'b0, MEM_WORD, 1'b0, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    // Misaligned half store
    run_op(1'b1, MEM_HALF, 1'b0, 32'h0000_4001, 32'h1234_5678, 32'h0, 0, 0, 0);
    // Memory stalls 5 cycles
    run_op(1'b1, MEM_HALF, 1'b0, 32'h0000_3002, 32'hCAFE_BEEF, 32'h0, 5, 0, 0);
    // Response held 3 cycles with stray m_rvalid
    run_op(1'b0, MEM_BYTE, 1'b1, 32'h0000_5001, 32'h0, 32'h1122_F344, 0, 2, 3);

    // Reset in WAIT, then a stray m_rvalid
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_part  = MEM_WORD;
    bus.req_addr  = 32'h0000_0100;
    tick();
    bus.req_valid = 1'b0;
    bus.m_ready   = 1'b1;
    tick();
    bus.m_ready   = 1'b0;
    chk("wait_before_rst_req_ready", 32'(bus.req_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h5555_AAAA;
    tick();
    bus.m_rvalid = 1'b0;
    chk("stray_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("stray_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("stray_resp_valid2", 32'(bus.resp_valid), 32'd0);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = {a[31:2], ($urandom_range(0, 1) != 0) ? 2'b00 : a[1:0]};
      run_op(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 The module SHALL declare: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 The module SHALL declare: reset  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL declare: req_valid  input  1  pipeline presents a memory operation.
REQ-004 The module SHALL declare: req_ready  output  1  unit accepts an operation this cycle.
REQ-005 The module SHALL declare: req_we  input  1  1 = store, 0 = load.
REQ-006 The module SHALL declare: req_part  input  2  access size, encoded as `memWord / `memHalf / `memByte.
REQ-007 The module SHALL declare: req_sext  input  1  load result is sign-extended (1) or zero-extended (0).
REQ-008 The module SHALL declare: req_addr  input  32  byte address.
REQ-009 The module SHALL declare: req_wdata  input  32  store data, right-aligned.
REQ-010 The module SHALL declare: m_valid, m_we  output  1 each  memory request and its write flag.
REQ-011 The module SHALL declare: m_addr  output  32  word-aligned address, req_addr with bits [1:0] forced to 0.
REQ-012 The module SHALL declare: m_be  output  4  byte enables.
REQ-013 The module SHALL declare: m_wdata  output  32  lane-replicated store data.
REQ-014 The module SHALL declare: m_ready  input  1  memory accepts the request.
REQ-015 The module SHALL declare: m_rvalid  input  1  load data valid.
REQ-016 The module SHALL declare: m_rdata  input  32  raw load word.
REQ-017 The module SHALL declare: resp_valid, resp_err  output  1 each  completion and misalignment flag.
REQ-018 The module SHALL declare: resp_data  output  32  extended load result.
REQ-019 The module SHALL declare: resp_ready  input  1  pipeline consumes the response.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; req_ready SHALL equal (state==IDLE).
REQ-021 Accept = req_valid & req_ready; on accept all req_* SHALL be registered, and no req_* input is used afterwards.
REQ-022 Misalignment SHALL be defined as: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 A misaligned accept SHALL go IDLE->RESP with resp_err=1 and resp_data=0; m_valid SHALL never assert for that operation.
REQ-024 An aligned accept SHALL go IDLE->ISSUE; m_valid=1 in the following cycle (one-cycle registered latency).
REQ-025 In ISSUE, m_valid/m_we/m_addr/m_be/m_wdata SHALL remain stable until m_ready=1.
REQ-026 In ISSUE with m_ready=1, a store SHALL go to RESP and a load SHALL go to WAIT; m_valid SHALL be 0 in every other state.
REQ-027 m_be SHALL be: word 4'b1111; half 4'b0011<<(2*addr[1]); byte 4'b0001<<addr[1:0]; m_be SHALL be 0 for loads.
REQ-028 m_wdata SHALL be: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-029 m_rvalid SHALL be ignored outside WAIT. In WAIT with m_rvalid=1, the unit SHALL select lane m_rdata[8*addr[1:0]+:8] (byte) or m_rdata[16*addr[1]+:16] (half), extend per req_sext, register the result into resp_data, and go to RESP.
REQ-030 In RESP, resp_valid=1 and resp_data/resp_err SHALL be held until resp_ready=1, then the FSM SHALL return to IDLE; stores SHALL return resp_data=0.
REQ-031 Back-to-back operation SHALL be supported: a new accept is possible the cycle after the RESP handshake; peak throughput is one operation per 3 cycles for stores.

Reset
REQ-032 Assertion of reset (reset=0) SHALL immediately force state=IDLE and all outputs to 0 except req_ready; req_ready SHALL read 1 after reset is released.
REQ-033 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation; a subsequent stray m_rvalid SHALL be ignored.

Structure
REQ-034 The encodings `memWord/`memHalf/`memByte SHALL come from the shared constants include; the FSM state encodings SHALL be defined there as well.
REQ-035 Lane logic (m_be, m_wdata, load extraction/extension) SHALL reside in one combinational sub-module, lsu_lane; lsu_port SHALL hold the FSM and registers.

Verification
REQ-036 The bench SHALL check: store `memByte, addr=0x1003, wdata=0x000000A5, m_ready=1 on the first ISSUE cycle -> m_addr=0x1000, m_be=4'b1000, m_wdata=0xA5A5A5A5, resp_valid two cycles after accept.
REQ-037 The bench SHALL check: load `memHalf, sext=1, addr=0x2002, m_rdata=0x8001_1234 -> resp_data=0xFFFF8001; the same access with sext=0 -> 0x00008001.
REQ-038 The bench SHALL check: load `memWord at addr=0x0006 -> resp_err=1 and m_valid never asserted.
REQ-039 The bench SHALL check: m_ready held 0 for 5 cycles -> m_addr/m_be/m_wdata stable throughout and req_ready=0.
REQ-040 The bench SHALL check: resp_ready=0 for 3 cycles -> resp_data held; an m_rvalid pulse during RESP is ignored.
REQ-041 The bench SHALL check: reset pulled low in WAIT, then m_rvalid=1 after release -> resp_valid stays 0 and req_ready=1.
